// File: rtl/master_addr_fifo_issue.sv
// Read-side issuer for the master address FIFO: 2-entry prefetch buffer feeding AXI4 AW/AR in strict FIFO order.
// Optional 4 KB boundary drop of INCR bursts is enabled with `define MASTER_ADDR_4K_CHECK_EN.
module master_addr_fifo_issue #(
    parameter int ID_WIDTH        = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int FIFO_DATA_WIDTH = 72
) (
    input  logic                       clk,
    input  logic                       rstn,
    output logic                       fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                       fifo_rd_empty,
    output logic [ID_WIDTH-1:0]        m_axi_awid,
    output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [ID_WIDTH-1:0]        m_axi_arid,
    output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    output logic                       busy,
    output logic                       err_4k
);

    logic [FIFO_DATA_WIDTH-1:0] buf_q [2];
    logic [FIFO_DATA_WIDTH-1:0] buf_d [2];
    logic                       hd_q, hd_d;
    logic                       tl_q, tl_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       pend_q, pend_d;

    logic [FIFO_DATA_WIDTH-1:0] head;
    logic                       head_vld;
    logic                       is_wr;
    logic                       viol;
    logic                       drop;
    logic                       deq;
    logic [2:0]                 occ;

    assign head     = buf_q[hd_q];
    assign head_vld = (cnt_q != 2'd0);
    assign is_wr    = head[0];

`ifdef MASTER_ADDR_4K_CHECK_EN
    logic [8:0]  len_p1;
    logic [16:0] nbytes;
    logic [16:0] span;
    logic        err_q;

    // 17 bits covers 4095 + 256 beats * 128 bytes without overflow
    assign len_p1 = {1'b0, head[31:24]} + 9'd1;
    assign nbytes = {8'd0, len_p1} << head[23:21];
    assign span   = {5'd0, head[43:32]} + nbytes;
    assign viol   = (head[20:19] == 2'b01) && (span > 17'd4096);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= drop;
        end
    end

    assign err_4k = err_q;
`else
    assign viol   = 1'b0;
    assign err_4k = 1'b0;
`endif

    assign drop = head_vld & viol;

    assign m_axi_awvalid = head_vld & is_wr & ~viol;
    assign m_axi_arvalid = head_vld & ~is_wr & ~viol;

    assign m_axi_awid    = head[64 +: ID_WIDTH];
    assign m_axi_awaddr  = head[32 +: ADDR_WIDTH];
    assign m_axi_awlen   = head[31:24];
    assign m_axi_awsize  = head[23:21];
    assign m_axi_awburst = head[20:19];
    assign m_axi_arid    = head[64 +: ID_WIDTH];
    assign m_axi_araddr  = head[32 +: ADDR_WIDTH];
    assign m_axi_arlen   = head[31:24];
    assign m_axi_arsize  = head[23:21];
    assign m_axi_arburst = head[20:19];

    assign deq = (m_axi_awvalid & m_axi_awready) | (m_axi_arvalid & m_axi_arready) | drop;

    // Occupancy after this cycle counting the read already in flight; never underflows since deq implies cnt>0
    assign occ        = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, deq};
    assign fifo_rd_en = ~fifo_rd_empty & (occ < 3'd2);
    assign busy       = head_vld | pend_q;

    always_comb begin
        buf_d  = buf_q;
        hd_d   = hd_q;
        tl_d   = tl_q;
        cnt_d  = occ[1:0];
        pend_d = fifo_rd_en;
        if (pend_q) begin
            buf_d[tl_q] = fifo_rd_data;
            tl_d        = ~tl_q;
        end
        if (deq) begin
            hd_d = ~hd_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            hd_q     <= 1'b0;
            tl_q     <= 1'b0;
            cnt_q    <= 2'd0;
            pend_q   <= 1'b0;
        end else begin
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            hd_q     <= hd_d;
            tl_q     <= tl_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

endmodule
